cla_seq_adder: RTL and testbench

//   Multi-cycle WIDTH-bit add/subtract unit that time-shares one 4-bit carry-lookahead slice.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla4_slice.sv | 29 ++
 rtl/cla_seq_adder.sv | 130 +++++++++++++
 tb/tb_cla_seq_adder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and elaboration helpers for the nibble-serial lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nib_w(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 8) && ((width % 4) == 0);
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder.sv
// Nibble-serial add/subtract: one shared 4-bit lookahead slice, LSB nibble first,
// with the inter-nibble carry held in a register.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = nib_w(NIB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("cla_seq_adder: WIDTH must be a multiple of 4 and >= 8");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0] sl_a;
    logic [3:0] sl_b;
    logic [3:0] sl_sum;
    logic       sl_cout;

    cla4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_comb begin
        sl_a = a_q[4*idx_q +: 4];
        sl_b = b_q[4*idx_q +: 4];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = sl_sum;
                carry_d = sl_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = sl_cout;
                    // MSB carry-in recovered from the MSB sum bit and its operands
                    ovf_d   = (sl_sum[3] ^ sl_a[3] ^ sl_b[3]) ^ sl_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

    localparam int W = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_pass = 0;
    int n_total = 0;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Reference: plain wide arithmetic on the two's-complement operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mcin, input logic msub,
                         output logic [W-1:0] ms, output logic mc,
                         output logic mo);
        logic [W:0]   full;
        logic [W-1:0] be;
        be   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, be} + (W+1)'(msub ? 1'b1 : mcin);
        ms   = full[W-1:0];
        mc   = full[W];
        mo   = (ma[W-1] == be[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    // Issue one operation and wait (bounded) for its result; leaves DONE held.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic isub,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("retire_out_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        logic [W-1:0] es, hs;
        logic ec, eo, hc, ho;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIB));
            check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
            check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
            retire();
            check($sformatf("vec%0d_hold_sum", i), 32'(sum), 32'(vecs[i].sum));
        end

        // Backpressure with a competing request held on the input
        issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, lat);
        model(16'h0F0F, 16'h00F1, 1'b1, 1'b0, hs, hc, ho);
        check("bp_sum", 32'(sum), 32'(hs));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b0; sub = 1'b0;
            check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("bp%0d_sum", k), 32'(sum), 32'(hs));
            check($sformatf("bp%0d_cout", k), 32'(cout), 32'(hc));
            check($sformatf("bp%0d_ovf", k), 32'(ovf), 32'(ho));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_sum", 32'(sum), 32'(hs));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_late_accept_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_late_sum", 32'(sum), 32'hBBBB);
        retire();

        // Reset in RUN after two nibbles have been written
        @(negedge clk);
        a = 16'h9999; b = 16'h7777; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_result", 32'(out_valid), 32'd0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, lat);
        check("mrst_next_sum", 32'(sum), 32'h0002);
        check("mrst_next_latency", 32'(lat), 32'(NIB));
        retire();

        // Randomised operations against the arithmetic reference
        for (int r = 0; r < 60; r++) begin
            logic [W-1:0] ra, rb;
            logic rc, rs;
            ra = $urandom; rb = $urandom; rc = $urandom; rs = $urandom;
            if (r % 10 == 0) ra = {1'b0, {(W-1){1'b1}}};
            model(ra, rb, rc, rs, es, ec, eo);
            issue(ra, rb, rc, rs, lat);
            check($sformatf("rnd%0d_sum", r), 32'(sum), 32'(es));
            check($sformatf("rnd%0d_cout", r), 32'(cout), 32'(ec));
            check($sformatf("rnd%0d_ovf", r), 32'(ovf), 32'(eo));
            check($sformatf("rnd%0d_latency", r), 32'(lat), 32'(NIB));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            retire();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
